// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction word constants and the PC wrap helper.
package cpu_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned WORD_BYTES  = 4;

    typedef enum logic [1:0] {REQ, RESP, HOLD, HALT} fetch_state_e;

    // Folds an already-incremented PC back into the memory window; callers pass zero-extended
    // ADDR_WIDTH values so the subtraction result always fits back into ADDR_WIDTH bits.
    function automatic logic [63:0] wrap_pc(input logic [63:0] x, input logic [63:0] bound);
        return (x >= bound) ? x - bound : x;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one memory read at a time and hands words to decode.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets (adds fetchFault and HALT).
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           MEM_BYTES  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic                   memoryRead,
    input  logic [INSTR_WIDTH-1:0] readData,
    input  logic                   dataAccess,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirectPc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instrPc,
    output logic [ADDR_WIDTH-1:0]  instrPcNext,
    output logic                   instrValid,
    input  logic                   instrReady
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                   fetchFault
`endif
);

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
    logic [ADDR_WIDTH-1:0]  ipcn_q, ipcn_d;
    logic                   valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  pc_inc;
    logic [ADDR_WIDTH-1:0]  pc_seq;

    assign pc_inc = pc_q + ADDR_WIDTH'(WORD_BYTES);
    assign pc_seq = ADDR_WIDTH'(wrap_pc(64'(pc_inc), 64'(MEM_BYTES)));

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic redirect_bad;

    assign redirect_bad = redirect && (redirectPc[1:0] != 2'b00);
    assign fetchFault   = fault_q;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        ipcn_d     = ipcn_q;
        valid_d    = valid_q;
        memoryRead = 1'b0;
        unique case (state_q)
            REQ: begin
                if (redirect) begin
                    pc_d = redirectPc;
                end else if (!dataAccess) begin
                    // Gated by rst so the port stays quiet while reset is held.
                    memoryRead = !rst;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (redirect) begin
                    pc_d    = redirectPc;
                    state_d = REQ;
                end else begin
                    instr_d = readData;
                    ipc_d   = pc_q;
                    ipcn_d  = pc_seq;
                    valid_d = 1'b1;
                    pc_d    = pc_seq;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirectPc;
                    state_d = REQ;
                end else if (instrReady) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
        if (redirect_bad) begin
            fault_d = 1'b1;
            valid_d = 1'b0;
            state_d = HALT;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            ipcn_q  <= '0;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipcn_q  <= ipcn_d;
            valid_q <= valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign address     = pc_q;
    assign instr       = instr_q;
    assign instrPc     = ipc_q;
    assign instrPcNext = ipcn_q;
    assign instrValid  = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a byte memory model feeds readData, the driver queues
// expected deliveries and a monitor checks every accepted handshake against the queue.
module tb_instruction_fetch;

    localparam int unsigned AW    = 32;
    localparam int unsigned MEMSZ = 64;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] address;
    logic          memoryRead;
    logic [31:0]   readData;
    logic          dataAccess;
    logic          redirect;
    logic [AW-1:0] redirectPc;
    logic [31:0]   instr;
    logic [AW-1:0] instrPc;
    logic [AW-1:0] instrPcNext;
    logic          instrValid;
    logic          instrReady;
`ifdef FETCH_ALIGN_CHECK_EN
    logic          fetchFault;
`endif

    logic [7:0] mem [0:MEMSZ-1];
    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    instruction_fetch #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (32'h0),
        .MEM_BYTES  (MEMSZ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .memoryRead  (memoryRead),
        .readData    (readData),
        .dataAccess  (dataAccess),
        .redirect    (redirect),
        .redirectPc  (redirectPc),
        .instr       (instr),
        .instrPc     (instrPc),
        .instrPcNext (instrPcNext),
        .instrValid  (instrValid),
        .instrReady  (instrReady)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetchFault  (fetchFault)
`endif
    );

    always #5 clk = ~clk;

    // Standard program words; unlisted addresses hold a marker carrying their own address.
    function automatic logic [31:0] word_at(input int a);
        case (a)
            0:       return 32'h0C20_0000;
            8:       return 32'h4020_0003;
            16:      return 32'hD000_000C;
            20:      return 32'h4020_0000;
            56:      return 32'hD400_0000;
            default: return 32'h1100_0000 | a;
        endcase
    endfunction

    always @(posedge clk) begin
        if (memoryRead) begin
            readData <= {mem[address[5:0]], mem[address[5:0] + 6'd1],
                         mem[address[5:0] + 6'd2], mem[address[5:0] + 6'd3]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int a);
        exp_t e;
        e.instr = word_at(a);
        e.pc    = a;
        e.pcn   = (a + 4) % MEMSZ;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    // Monitor: every accepted handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            sample();
            if (!rst) begin
                check("mem_port_conflict", {31'b0, memoryRead & dataAccess}, 32'h0);
                if (instrValid && instrReady && !redirect) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_delivery: got pc 0x%08h instr 0x%08h expected none",
                                 instrPc, instr);
                    end else begin
                        e = sb.pop_front();
                        check("sb_instr", instr, e.instr);
                        check("sb_pc", instrPc, e.pc);
                        check("sb_pcnext", instrPcNext, e.pcn);
                    end
                end
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the edge that saw valid.
    task automatic wait_valid(input string name);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (instrValid) begin
                got = 1;
                break;
            end
            step();
        end
        check(name, {31'b0, got}, 32'h1);
        step();
    endtask

    task automatic accept_one(input string name);
        bit got = 0;
        instrReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (instrValid) got = 1;
            step();
            if (got) break;
        end
        instrReady = 1'b0;
        check(name, {31'b0, got}, 32'h1);
    endtask

    initial begin
        logic [31:0] w;
        bit drained;
        for (int a = 0; a < int'(MEMSZ); a += 4) begin
            w = word_at(a);
            mem[a]   = w[31:24];
            mem[a+1] = w[23:16];
            mem[a+2] = w[15:8];
            mem[a+3] = w[7:0];
        end
        rst        = 1'b1;
        dataAccess = 1'b0;
        redirect   = 1'b0;
        redirectPc = '0;
        instrReady = 1'b1;

        // Reset state, then first fetch and a full free run across the wrap.
        step();
        step();
        sample();
        check("rst_valid", {31'b0, instrValid}, 32'h0);
        check("rst_memread", {31'b0, memoryRead}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instrpc", instrPc, 32'h0);
        check("rst_instrpcnext", instrPcNext, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_fault", {31'b0, fetchFault}, 32'h0);
`endif
        for (int a = 0; a < int'(MEMSZ); a += 4) push(a);
        push(0);
        step();
        rst = 1'b0;
        sample();
        check("first_memread", {31'b0, memoryRead}, 32'h1);
        check("first_address", address, 32'h0);
        check("first_valid_early", {31'b0, instrValid}, 32'h0);
        step();
        sample();
        check("resp_memread", {31'b0, memoryRead}, 32'h0);
        step();
        sample();
        check("latency_valid", {31'b0, instrValid}, 32'h1);
        drained = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sb.size() == 0) begin
                drained = 1;
                break;
            end
        end
        rst = 1'b1;
        check("freerun_drained", {31'b0, drained}, 32'h1);

        // Stall in HOLD at pc 8, then dataAccess at pc 20.
        instrReady = 1'b0;
        sb.delete();
        step();
        step();
        rst = 1'b0;
        push(0);
        accept_one("acc_0");
        push(4);
        accept_one("acc_4");
        push(8);
        wait_valid("wait_8");
        for (int i = 0; i < 5; i++) begin
            sample();
            check("hold_instr", instr, 32'h4020_0003);
            check("hold_pc", instrPc, 32'h8);
            check("hold_valid", {31'b0, instrValid}, 32'h1);
            check("hold_memread", {31'b0, memoryRead}, 32'h0);
            step();
        end
        accept_one("acc_8");
        sample();
        check("after_hold_memread", {31'b0, memoryRead}, 32'h1);
        check("after_hold_address", address, 32'hC);
        step();
        push(12);
        accept_one("acc_12");
        push(16);
        accept_one("acc_16");
        dataAccess = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("dacc_memread", {31'b0, memoryRead}, 32'h0);
            check("dacc_address", address, 32'h14);
            step();
        end
        dataAccess = 1'b0;
        sample();
        check("dacc_resume_memread", {31'b0, memoryRead}, 32'h1);
        check("dacc_resume_address", address, 32'h14);
        step();
        push(20);
        accept_one("acc_20");

        // Redirect in REQ, then in RESP of the CALL at 16.
        redirect   = 1'b1;
        redirectPc = 32'h10;
        sample();
        check("redir_req_memread", {31'b0, memoryRead}, 32'h0);
        step();
        redirect = 1'b0;
        sample();
        check("redir_req_address", address, 32'h10);
        check("redir_req_memread2", {31'b0, memoryRead}, 32'h1);
        step();
        redirect   = 1'b1;
        redirectPc = 32'h38;
        step();
        redirect = 1'b0;
        sample();
        check("redir_resp_valid", {31'b0, instrValid}, 32'h0);
        check("redir_resp_address", address, 32'h38);
        check("redir_resp_memread", {31'b0, memoryRead}, 32'h1);
        step();
        push(56);
        accept_one("acc_56");

        // Redirect in HOLD beats instrReady: the word at 60 is dropped.
        wait_valid("wait_60");
        instrReady = 1'b1;
        redirect   = 1'b1;
        redirectPc = 32'h4;
        step();
        redirect   = 1'b0;
        instrReady = 1'b0;
        sample();
        check("redir_hold_valid", {31'b0, instrValid}, 32'h0);
        check("redir_hold_address", address, 32'h4);
        step();

`ifdef FETCH_ALIGN_CHECK_EN
        redirect   = 1'b1;
        redirectPc = 32'h1A;
        step();
        redirect = 1'b0;
        sample();
        check("fault_set", {31'b0, fetchFault}, 32'h1);
        check("fault_valid", {31'b0, instrValid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("fault_memread", {31'b0, memoryRead}, 32'h0);
            step();
            sample();
        end
        check("fault_sticky", {31'b0, fetchFault}, 32'h1);
        step();
        rst = 1'b1;
        step();
        sample();
        check("fault_cleared", {31'b0, fetchFault}, 32'h0);
        step();
        rst = 1'b0;
        sample();
        check("fault_restart_memread", {31'b0, memoryRead}, 32'h1);
        check("fault_restart_address", address, 32'h0);
        step();
`endif

        check("sb_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
